// File: rtl/logic_gate_sweep.sv
// N-input logic gate with registered output and a truth-table sweep engine.
// Optional macro TT_POPCOUNT_EN adds ones_cnt, the popcount of the captured table.
module logic_gate_sweep #(
  parameter int N_IN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           op,
  input  logic [N_IN-1:0]      in,
  input  logic                 in_valid,
  output logic                 y,
  output logic                 y_valid,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [(1<<N_IN)-1:0] tt
`ifdef TT_POPCOUNT_EN
  ,
  output logic [N_IN:0]        ones_cnt
`endif
);

  localparam int TT_W  = 1 << N_IN;
  localparam int IDX_W = N_IN + 1;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic              y_q, y_d;
  logic              yv_q, yv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  function automatic logic gate_f(
    input logic [2:0]      f_op,
    input logic [N_IN-1:0] x
  );
    logic r;
    unique case (f_op)
      3'b000: r = &x;
      3'b001: r = |x;
      3'b010: r = ^x;
      3'b011: r = ~(&x);
      3'b100: r = ~(|x);
      3'b101: r = ~(^x);
      3'b110: r = x[0];
      3'b111: r = ~x[0];
    endcase
    return r;
  endfunction

  // Next-state: normal evaluation in IDLE, one table bit per SWEEP cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    tt_d    = tt_q;
    y_d     = y_q;
    yv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          op_d    = op;
          tt_d    = '0;
          idx_d   = '0;
        end else if (in_valid) begin
          y_d  = gate_f(op, in);
          yv_d = 1'b1;
        end
      end
      SWEEP: begin
        tt_d[idx_q[N_IN-1:0]] = gate_f(op_q, idx_q[N_IN-1:0]);
        idx_d = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SWEEP);
    done_d = (state_d == DONE);
  end

  // State and output registers; status flags track the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      idx_q   <= '0;
      tt_q    <= '0;
      y_q     <= 1'b0;
      yv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      tt_q    <= tt_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign y       = y_q;
  assign y_valid = yv_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign tt      = tt_q;

`ifdef TT_POPCOUNT_EN
  logic [N_IN:0] cnt_q, cnt_d;

  // Popcount of the finished table, captured alongside the done pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && start) begin
      cnt_d = '0;
    end else if (state_q == SWEEP && state_d == DONE) begin
      cnt_d = IDX_W'($countones(tt_d));
    end
  end

  // Popcount register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ones_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_logic_gate_sweep.sv
// Scoreboard bench for logic_gate_sweep at N_IN=2 and N_IN=3.
// Stimulus pushes expected y / tt values; monitors pop on y_valid / done.
module tb_logic_gate_sweep;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] a_op = '0;
  logic [1:0] a_in = '0;
  logic       a_iv = 1'b0;
  logic       a_start = 1'b0;
  logic       a_y, a_yv, a_busy, a_done;
  logic [3:0] a_tt;

  logic [2:0] b_op = '0;
  logic [2:0] b_in = '0;
  logic       b_iv = 1'b0;
  logic       b_start = 1'b0;
  logic       b_y, b_yv, b_busy, b_done;
  logic [7:0] b_tt;

`ifdef TT_POPCOUNT_EN
  logic [2:0] a_ones;
  logic [3:0] b_ones;
`endif

  logic       a_yq[$];
  logic [3:0] a_tq[$];
  logic       b_yq[$];
  logic [7:0] b_tq[$];

  int n_vec = 0;
  int n_bad = 0;

  logic_gate_sweep #(.N_IN(2)) u_a (
    .clk(clk), .rst(rst), .op(a_op), .in(a_in),
    .in_valid(a_iv), .y(a_y), .y_valid(a_yv),
    .start(a_start), .busy(a_busy), .done(a_done),
    .tt(a_tt)
`ifdef TT_POPCOUNT_EN
    , .ones_cnt(a_ones)
`endif
  );

  logic_gate_sweep #(.N_IN(3)) u_b (
    .clk(clk), .rst(rst), .op(b_op), .in(b_in),
    .in_valid(b_iv), .y(b_y), .y_valid(b_yv),
    .start(b_start), .busy(b_busy), .done(b_done),
    .tt(b_tt)
`ifdef TT_POPCOUNT_EN
    , .ones_cnt(b_ones)
`endif
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: unexpected pulse, none expected", nm);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the N_IN=2 instance.
  initial begin
    int bcnt;
    logic [3:0] e;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bcnt = 0;
      end else begin
        if (a_busy) bcnt++;
        if (a_yv) begin
          if (a_yq.size() == 0) unexp("a_y_valid");
          else chk("a_y", 32'(a_y), 32'(a_yq.pop_front()));
        end
        if (a_done) begin
          if (a_tq.size() == 0) begin
            unexp("a_done");
          end else begin
            e = a_tq.pop_front();
            chk("a_tt", 32'(a_tt), 32'(e));
            chk("a_busy_len", bcnt, 4);
            chk("a_busy_at_done", 32'(a_busy), 0);
`ifdef TT_POPCOUNT_EN
            chk("a_ones", 32'(a_ones), $countones(e));
`endif
          end
          bcnt = 0;
        end
      end
    end
  end

  // Monitor for the N_IN=3 instance.
  initial begin
    int bcnt;
    logic [7:0] e;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bcnt = 0;
      end else begin
        if (b_busy) bcnt++;
        if (b_yv) begin
          if (b_yq.size() == 0) unexp("b_y_valid");
          else chk("b_y", 32'(b_y), 32'(b_yq.pop_front()));
        end
        if (b_done) begin
          if (b_tq.size() == 0) begin
            unexp("b_done");
          end else begin
            e = b_tq.pop_front();
            chk("b_tt", 32'(b_tt), 32'(e));
            chk("b_busy_len", bcnt, 8);
            chk("b_busy_at_done", 32'(b_busy), 0);
`ifdef TT_POPCOUNT_EN
            chk("b_ones", 32'(b_ones), $countones(e));
`endif
          end
          bcnt = 0;
        end
      end
    end
  end

  // {op[2:0], in[1:0], expected y}
  logic [5:0] vecs [11] = '{
    6'b011_11_0, 6'b011_01_1, 6'b000_11_1,
    6'b000_10_0, 6'b001_00_0, 6'b010_01_1,
    6'b010_11_0, 6'b100_00_1, 6'b101_10_0,
    6'b110_10_0, 6'b111_10_1
  };

  initial begin
    logic [5:0] v;
    rst = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_a_y", 32'(a_y), 0);
    chk("rst_a_yv", 32'(a_yv), 0);
    chk("rst_a_busy", 32'(a_busy), 0);
    chk("rst_a_done", 32'(a_done), 0);
    chk("rst_a_tt", 32'(a_tt), 0);
    chk("rst_b_tt", 32'(b_tt), 0);
    cyc();
    rst = 1'b0;

    // OR sweep
    a_op = 3'b001; a_start = 1'b1;
    a_tq.push_back(4'b1110);
    cyc();
    a_start = 1'b0;
    repeat (6) cyc();

    // XOR sweep on N_IN=3, op changed mid-sweep
    b_op = 3'b010; b_start = 1'b1;
    b_tq.push_back(8'b1001_0110);
    cyc();
    b_start = 1'b0;
    cyc();
    cyc();
    b_op = 3'b000;
    repeat (9) cyc();

    // Normal evaluations, back to back
    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      a_op = v[5:3];
      a_in = v[2:1];
      a_iv = 1'b1;
      a_yq.push_back(v[0]);
      cyc();
    end
    a_iv = 1'b0;
    cyc();
    cyc();

    // start + in_valid together; restart attempt mid-sweep
    a_op = 3'b000; a_in = 2'b11;
    a_start = 1'b1; a_iv = 1'b1;
    a_tq.push_back(4'b1000);
    cyc();
    a_start = 1'b0; a_iv = 1'b0;
    cyc();
    a_op = 3'b111; a_start = 1'b1;
    cyc();
    a_start = 1'b0;
    repeat (5) cyc();

    // BUF sweep, in_valid during sweep must be dropped
    a_op = 3'b110; a_start = 1'b1;
    a_tq.push_back(4'b1010);
    cyc();
    a_start = 1'b0;
    a_in = 2'b10; a_iv = 1'b1;
    cyc();
    a_iv = 1'b0;
    repeat (5) cyc();
    @(negedge clk);
    chk("a_y_hold", 32'(a_y), 1);
    cyc();

    // NOT sweep
    a_op = 3'b111; a_start = 1'b1;
    a_tq.push_back(4'b0101);
    cyc();
    a_start = 1'b0;
    repeat (6) cyc();

    // Set b's y, then reset during its sweep
    b_op = 3'b001; b_in = 3'b001; b_iv = 1'b1;
    b_yq.push_back(1'b1);
    cyc();
    b_iv = 1'b0;
    cyc();
    b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(b_busy), 0);
    chk("mid_rst_done", 32'(b_done), 0);
    chk("mid_rst_tt", 32'(b_tt), 0);
    chk("mid_rst_y", 32'(b_y), 0);
    repeat (12) cyc();

    // Full XNOR sweep after the aborted one
    b_op = 3'b101; b_start = 1'b1;
    b_tq.push_back(8'b0110_1001);
    cyc();
    b_start = 1'b0;
    repeat (10) cyc();

    for (int i = 0; i < 20; i++) begin
      if (a_yq.size() == 0 && a_tq.size() == 0 &&
          b_yq.size() == 0 && b_tq.size() == 0) break;
      cyc();
    end
    chk("drain_a_y", a_yq.size(), 0);
    chk("drain_a_tt", a_tq.size(), 0);
    chk("drain_b_y", b_yq.size(), 0);
    chk("drain_b_tt", b_tq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/logic_gate_sweep.md
Name: logic_gate_sweep

Overview:
Parametrised N-input logic gate with a runtime-selectable operation and a registered output. Adds a built-in truth-table sweep engine: on a start pulse it walks all 2^N_IN input combinations and captures the gate response into a truth-table register. This replaces fixed 2-input gates plus hand-written truth-table benches, and supports on-chip self-check of gate functions.

Parameters:
N_IN, 2, number of gate inputs; legal range 1..8.
TT_W, 1<<N_IN, truth-table width; derived, never overridden.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
op  input  3  operation select: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 BUF in[0], 111 NOT in[0].
in  input  N_IN  gate inputs for normal evaluation.
in_valid  input  1  request a normal evaluation of in.
y  output  1  registered gate result.
y_valid  output  1  y updated this cycle; single-cycle pulse.
start  input  1  begin a truth-table sweep; sampled in IDLE only.
busy  output  1  sweep in progress.
done  output  1  sweep complete; single-cycle pulse.
tt  output  TT_W  captured truth table; bit i = f(op, i).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Reset values: y=0, y_valid=0, busy=0, done=0, tt=0, idx=0, state=IDLE.
- Reductions are over all N_IN bits. With N_IN=1, AND/OR/XOR return in[0]; NAND/NOR/XNOR return ~in[0].
- States:
  - IDLE: waiting for work.
  - SWEEP: busy=1.
  - DONE: one cycle, done=1, busy=0.
- Normal path (IDLE only):
  - in_valid=1 at edge k -> y=f(op,in) and y_valid=1 after edge k+1. Latency 1 cycle.
  - Otherwise y_valid=0 and y holds its last value.
- in_valid in SWEEP or DONE is dropped: y and y_valid are unaffected, and there is no queueing.
- IDLE + start=1:
  - Latch op into op_q, clear tt, set idx=0, go to SWEEP.
  - start has priority over in_valid in the same cycle; the in_valid request is dropped.
- SWEEP, each cycle:
  - tt[idx] <= f(op_q, idx[N_IN-1:0]); idx <= idx+1.
  - When idx==TT_W-1, write the final bit and go to DONE.
  - Exactly TT_W SWEEP cycles.
- Changes on op during SWEEP are ignored because op_q is used.
- start in SWEEP or DONE is ignored; there is no restart.
- DONE -> IDLE unconditionally.
- Sweep timing: start sampled at edge 0 -> busy high after edges 1..TT_W -> done high for the cycle after edge TT_W+1.
- tt holds its value until the next accepted start or reset.
- idx is N_IN+1 bits wide, so the terminal compare cannot wrap; idx is unused outside SWEEP.
- Reset mid-sweep: immediate return to the reset values; the partial tt is discarded (tt=0) and no done pulse is issued.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: TT_POPCOUNT_EN.
- When defined:
  - Extra output ones_cnt [N_IN:0] = number of 1 bits in tt.
  - Updated in the same cycle done is asserted; holds until the next done.
  - Reset to 0; also cleared on accepted start.
- When not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- N_IN=2, op=001, start pulse -> busy for 4 cycles, done one cycle later, tt=4'b1110; with TT_POPCOUNT_EN, ones_cnt=3.
- N_IN=3, op=010, start -> tt=8'b10010110 after 8 SWEEP cycles; op switched to 000 mid-sweep has no effect.
- N_IN=2, IDLE, op=011, in=2'b11, in_valid=1 -> next cycle y=0, y_valid=1; then in=2'b01 -> y=1; y_valid low when in_valid=0.
- start and in_valid in the same IDLE cycle -> sweep begins, no y_valid pulse. start re-pulsed mid-sweep -> ignored, single done.
- rst asserted at SWEEP cycle 2 of an N_IN=3 sweep -> next cycle busy=0, done=0, tt=0, y=0; a new start then gives a full, correct sweep.
- op=110 and op=111, N_IN=2 sweep -> tt=4'b1010 and 4'b0101 respectively.
